// File: rtl/pulse_cnt_reporter_pkg.sv
// Shared constants and state encoding for the pulse-count snapshot reporter.
package pulse_cnt_pkg;

    localparam int unsigned N_CH  = 16;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned CH_W  = 5;
    localparam int unsigned IDX_W = 4;

    localparam logic [CH_W-1:0] CHK_CHAN = CH_W'(16);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        SUM  = 2'd2
    } state_t;

endpackage

// File: rtl/pulse_cnt_reporter_if.sv
// Valid/ready word stream carrying snapshot counts followed by a checksum word.
interface pulse_cnt_reporter_if;
    import pulse_cnt_pkg::*;

    logic             o_valid;
    logic             i_ready;
    logic [CNT_W-1:0] o_data;
    logic [CH_W-1:0]  o_chan;
    logic             o_last;

    modport master (output o_valid, output o_data, output o_chan, output o_last, input i_ready);
    modport slave  (input o_valid, input o_data, input o_chan, input o_last, output i_ready);

endinterface

// File: rtl/pulse_cnt_reporter_edge.sv
// Registers a 1-bit level and flags the cycle on which it is sampled low after being high.
module edge_fall_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic fall
);

    logic d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) d_q <= 1'b0;
        else        d_q <= d;
    end

    assign fall = d_q & ~d;

endmodule

// File: rtl/pulse_cnt_reporter.sv
// Snapshots all channel counts when the counting window closes and streams them
// as N_CH count words plus a modular-sum checksum word.
module pulse_cnt_reporter
    import pulse_cnt_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic [N_CH*CNT_W-1:0] i_cnt_bus,
    pulse_cnt_reporter_if.master  bus,
    output logic                  o_overrun,
    output logic [15:0]           o_frame_cnt
);

    state_t           state, state_nx;
    logic             close_evt;
    logic             xfer;
    logic [CNT_W-1:0] snap [N_CH];
    logic [CH_W-1:0]  idx;
    logic [CNT_W-1:0] acc;

    edge_fall_det u_en_fall (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .d     (i_en),
        .fall  (close_evt)
    );

    assign xfer = bus.o_valid & bus.i_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < N_CH; i++) snap[i] <= '0;
            idx         <= '0;
            acc         <= '0;
            o_overrun   <= 1'b0;
            o_frame_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (close_evt) begin
                        for (int unsigned i = 0; i < N_CH; i++)
                            snap[i] <= i_cnt_bus[i*CNT_W +: CNT_W];
                        idx <= '0;
                        acc <= '0;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        acc <= acc + bus.o_data;
                        idx <= idx + CH_W'(1);
                    end
                end
                SUM: begin
                    if (xfer) o_frame_cnt <= o_frame_cnt + 16'd1;
                end
                default: ;
            endcase
            // A window closing mid-frame is dropped; the in-flight frame keeps its snapshot.
            if (close_evt && state != IDLE) o_overrun <= 1'b1;
        end
    end

    always_comb begin
        state_nx    = state;
        bus.o_valid = 1'b0;
        bus.o_data  = '0;
        bus.o_chan  = '0;
        bus.o_last  = 1'b0;
        case (state)
            IDLE: begin
                if (close_evt) state_nx = SEND;
            end
            SEND: begin
                bus.o_valid = 1'b1;
                bus.o_chan  = idx;
                bus.o_data  = snap[idx[IDX_W-1:0]];
                if (xfer && idx == CH_W'(N_CH - 1)) state_nx = SUM;
            end
            SUM: begin
                bus.o_valid = 1'b1;
                bus.o_chan  = CHK_CHAN;
                bus.o_data  = acc;
                bus.o_last  = 1'b1;
                if (xfer) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pulse_cnt_reporter.sv
// Scoreboard bench for pulse_cnt_reporter: expected frames are queued when a window
// is closed and compared word by word as the DUT hands them over.
module tb_pulse_cnt_reporter;

    typedef struct packed {
        logic [4:0]  chan;
        logic [15:0] data;
        logic        last;
    } word_t;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [255:0] cnt_bus;
    logic         overrun;
    logic [15:0]  frame_cnt;

    pulse_cnt_reporter_if bus_if ();

    pulse_cnt_reporter dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_en        (en),
        .i_cnt_bus   (cnt_bus),
        .bus         (bus_if),
        .o_overrun   (overrun),
        .o_frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_fail   = 0;
    word_t sb[$];
    int    xfer_cnt   = 0;
    int    valid_seen = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: compare accepted words, and verify words are held while stalled.
    initial begin
        word_t held;
        word_t exp_w;
        bit    held_v;
        held_v = 0;
        held   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held_v = 0;
            end else begin
                if (held_v)
                    check_eq("stall_hold",
                             32'({bus_if.o_valid, bus_if.o_chan, bus_if.o_data, bus_if.o_last}),
                             32'({1'b1, held}));
                if (bus_if.o_valid) valid_seen++;
                if (bus_if.o_valid && bus_if.i_ready) begin
                    xfer_cnt++;
                    check_eq("sb_level", 32'(sb.size() > 0), 32'd1);
                    if (sb.size() > 0) begin
                        exp_w = sb.pop_front();
                        check_eq("word",
                                 32'({bus_if.o_chan, bus_if.o_data, bus_if.o_last}),
                                 32'(exp_w));
                    end
                    held_v = 0;
                end else if (bus_if.o_valid) begin
                    held_v = 1;
                    held   = {bus_if.o_chan, bus_if.o_data, bus_if.o_last};
                end else begin
                    held_v = 0;
                end
            end
        end
    end

    function automatic logic [255:0] rand_bus();
        logic [255:0] v;
        for (int k = 0; k < 16; k++) v[k*16 +: 16] = 16'($urandom);
        return v;
    endfunction

    // Open then close a window; counts change right after the capture edge.
    task automatic close_window(input logic [255:0] v);
        logic [15:0] sum;
        logic [15:0] w;
        @(posedge clk); #1;
        cnt_bus = v;
        en      = 1'b1;
        @(posedge clk); #1;
        en  = 1'b0;
        sum = '0;
        for (int k = 0; k < 16; k++) begin
            w = v[k*16 +: 16];
            sb.push_back('{chan: 5'(k), data: w, last: 1'b0});
            sum = sum + w;
        end
        sb.push_back('{chan: 5'd16, data: sum, last: 1'b1});
        @(posedge clk); #1;
        cnt_bus = ~v;
    endtask

    task automatic wait_frame(input int mode, input int budget);
        int c;
        c = 0;
        while (sb.size() != 0 && c < budget) begin
            @(posedge clk); #1;
            if (mode == 1) bus_if.i_ready = (c % 3 == 0);
            c++;
        end
        check_eq("frame_done", 32'(sb.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_chan(input logic [4:0] ch);
        int c;
        c = 0;
        while (bus_if.o_chan != ch && c < 40) begin
            @(posedge clk); #1;
            c++;
        end
        check_eq("reach_chan", 32'(bus_if.o_chan), 32'(ch));
    endtask

    initial begin
        logic [255:0] v;
        int           x0;
        rst_n          = 1'b0;
        en             = 1'b0;
        cnt_bus        = '0;
        bus_if.i_ready = 1'b0;
        #12;
        check_eq("rst_valid", 32'(bus_if.o_valid), 32'd0);
        check_eq("rst_word", 32'({bus_if.o_chan, bus_if.o_data, bus_if.o_last}), 32'd0);
        check_eq("rst_overrun", 32'(overrun), 32'd0);
        check_eq("rst_frames", 32'(frame_cnt), 32'd0);
        #10 rst_n = 1'b1;

        // Enable never high: nothing may be sent.
        repeat (100) @(posedge clk);
        #1;
        check_eq("idle_valid", 32'(valid_seen), 32'd0);
        check_eq("idle_frames", 32'(frame_cnt), 32'd0);
        check_eq("idle_overrun", 32'(overrun), 32'd0);

        // Counts 1..16 with ready held high.
        bus_if.i_ready = 1'b1;
        for (int k = 0; k < 16; k++) v[k*16 +: 16] = 16'(k + 1);
        x0 = xfer_cnt;
        close_window(v);
        wait_frame(0, 40);
        check_eq("f1_frames", 32'(frame_cnt), 32'd1);
        check_eq("f1_xfers", 32'(xfer_cnt - x0), 32'd17);

        // All 0xFFFF with ready high one cycle in three.
        bus_if.i_ready = 1'b0;
        v = '1;
        x0 = xfer_cnt;
        close_window(v);
        wait_frame(1, 200);
        check_eq("f2_frames", 32'(frame_cnt), 32'd2);
        check_eq("f2_xfers", 32'(xfer_cnt - x0), 32'd17);
        check_eq("f2_overrun", 32'(overrun), 32'd0);

        // Second window closes while word 5 is on the bus.
        repeat (20) @(posedge clk);
        #1;
        bus_if.i_ready = 1'b1;
        x0 = xfer_cnt;
        close_window(rand_bus());
        wait_chan(5'd5);
        en = 1'b1;
        @(posedge clk); #1;
        en      = 1'b0;
        cnt_bus = rand_bus();
        wait_frame(0, 40);
        check_eq("ovr_flag", 32'(overrun), 32'd1);
        check_eq("ovr_frames", 32'(frame_cnt), 32'd3);
        repeat (30) @(posedge clk);
        #1;
        check_eq("ovr_xfers", 32'(xfer_cnt - x0), 32'd17);
        check_eq("ovr_sticky", 32'(overrun), 32'd1);

        // Reset while channel 7 is pending.
        close_window(rand_bus());
        wait_chan(5'd7);
        bus_if.i_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_valid", 32'(bus_if.o_valid), 32'd0);
        check_eq("arst_chan", 32'(bus_if.o_chan), 32'd0);
        check_eq("arst_overrun", 32'(overrun), 32'd0);
        check_eq("arst_frames", 32'(frame_cnt), 32'd0);
        sb.delete();
        @(posedge clk); #3;
        rst_n = 1'b1;
        bus_if.i_ready = 1'b1;
        x0 = valid_seen;
        repeat (10) @(posedge clk);
        #1;
        check_eq("arst_no_resume", 32'(valid_seen - x0), 32'd0);
        x0 = xfer_cnt;
        close_window(rand_bus());
        wait_frame(0, 40);
        check_eq("post_rst_frames", 32'(frame_cnt), 32'd1);
        check_eq("post_rst_xfers", 32'(xfer_cnt - x0), 32'd17);
        check_eq("post_rst_overrun", 32'(overrun), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pulse_cnt_reporter.md
Name: pulse_cnt_reporter

Overview:
- Downstream of the 16-channel pulse counter (vlg_design).
- Takes a snapshot of all 16 channel counts when a counting window closes, i.e. on the falling edge of the shared enable.
- Streams the snapshot over a valid/ready interface as 16 count words plus one checksum word.
- Feeds the host/UART framing stage that follows it.

Parameters:
- N_CH, 16, number of counter channels; fixed at 16 in this design.
- CNT_W, 16, width of each channel count and of the checksum.
- CH_W, 5, width of the channel index; must cover 0..N_CH.

Ports:
- i_clk  in  1  system clock, 100 MHz.
- i_rst_n  in  1  asynchronous active-low reset.
- i_en  in  1  counting-window enable, same signal that drives the counter.
- i_cnt_bus  in  N_CH*CNT_W  flattened counts; channel k occupies bits [k*CNT_W +: CNT_W]; channel 0 is the LSBs.
- o_valid  out  1  output word valid.
- i_ready  in  1  downstream accepts the word.
- o_data  out  CNT_W  count word or checksum.
- o_chan  out  CH_W  channel index 0..15; value 16 marks the checksum word.
- o_last  out  1  high only with the checksum word.
- o_overrun  out  1  sticky: a window closed while a frame was still being sent.
- o_frame_cnt  out  16  number of frames fully delivered; wraps modulo 65536.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values: o_valid=0, o_data=0, o_chan=0, o_last=0, o_overrun=0, o_frame_cnt=0, en_d=0, state=IDLE, snapshot=0.
- Reset mid-frame abandons the frame; no partial frame is completed afterwards.
- Edge detect: en_d is i_en registered. A close event occurs at clock edge k when en_d=1 and i_en=0, i.e. i_en was high at edge k-1 and low at edge k.
- IDLE:
  - On a close event, capture i_cnt_bus into the snapshot register at edge k.
  - Set word index to 0 and checksum accumulator to 0; go to SEND.
  - o_valid=1 from edge k onward, giving 1 cycle of latency from i_en sampled low.
- SEND:
  - o_valid=1, o_chan=index, o_data=snapshot[index], o_last=0.
  - A transfer happens on a clock edge where o_valid and i_ready are both 1.
  - On each transfer: accumulator += o_data (mod 2^CNT_W) and index++.
  - The transfer of index 15 moves the block to SUM.
- SUM:
  - o_valid=1, o_chan=16, o_data=accumulator (sum of all 16 snapshot words mod 65536), o_last=1.
  - On transfer: o_frame_cnt++, o_valid=0, o_last=0; go to IDLE.
- Handshake rules:
  - Once o_valid rises, it stays high and o_data/o_chan/o_last stay stable until the transfer.
  - o_valid never depends combinationally on i_ready.
  - i_ready may be held high continuously. The minimum frame is then 17 consecutive cycles, and IDLE is re-entered on the cycle after the checksum transfer.
- Overrun: a close event while in SEND or SUM is dropped and sets o_overrun=1. The snapshot is not modified and the current frame continues. o_overrun clears only on reset.
- A close event on the same edge as the checksum transfer counts as an overrun. IDLE must be reached first.
- Rising edges of i_en and activity on i_cnt_bus outside the capture edge have no effect.
- i_en held low from reset generates no frame, because en_d resets to 0.
- Back-to-back windows separated by ≥18 cycles of i_en low-then-high produce independent frames.

Decomposition:
- Shared package pulse_cnt_pkg holds:
  - N_CH, CNT_W, CH_W.
  - CHK_CHAN=16.
  - State encoding IDLE=0, SEND=1, SUM=2.
- Optional sub-module edge_fall_det: 1-bit register plus fall pulse, async active-low reset. It is reusable by the counter block.
- Everything else (snapshot registers, index, accumulator, FSM) lives in the top.

Test Plan:
- Reset, then i_en stays 0 for 100 cycles -> o_valid never rises; o_frame_cnt=0; o_overrun=0.
- Counts are 1..16 (channel k = k+1), i_en goes 1→0, i_ready=1 -> 17 consecutive words:
  - chan 0..15 carry data 1..16;
  - chan 16 carries data 136 with o_last=1;
  - o_frame_cnt becomes 1.
- All counts 0xFFFF, i_ready toggling 1-of-3 cycles -> data and chan stay stable while stalled; checksum 0xFFF0 (16*0xFFFF mod 2^16); 17 transfers exactly.
- Second close event during word 5 of a frame -> frame finishes with original data; o_overrun=1; o_frame_cnt rises by 1 only.
- Reset asserted while chan=7 is pending -> o_valid=0 asynchronously. After release, a new window produces a full frame starting at chan 0.
- i_cnt_bus changes on the cycle after capture -> frame data equals the values sampled at the capture edge.
